dmem_cache_resp: RTL

//  Data-side memory responder for the pipelined core's load/store port.
//  - Answers CPU requests through a valid/ready handshake.
//  - Direct-mapped, one word per line, write-through, no-write-allocate.
//  - Forwards misses and all stores to a backing memory over a req/ack handshake.
//  - Sits between the core's memory stage and the backing data memory.

---
 rtl/dmem_cache_resp_if.sv | 32 +++
 rtl/dmem_cache_resp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache_resp_if.sv
// dmem_cache_resp_if: CPU load/store port and backing-memory port of the
// data cache responder, bundled together.
// The slave modport is the cache itself. The master modport is its
// surroundings: the core's memory stage plus the backing memory.
interface dmem_cache_resp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_cache_resp.sv
// dmem_cache_resp: direct-mapped data cache for the core's load/store port.
// It holds one word per line and is write-through with no write-allocate.
// Load misses and all stores go to the backing memory over req/ack.
// Defining DCACHE_STATS_EN adds saturating load hit/miss counters.
// Without that macro, hit_cnt and miss_cnt are tied to zero.
module dmem_cache_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_cache_resp_if.slave bus,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:2]   addr_reg;       // latched word address
  logic                    we_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    hit_reg;        // store hit/miss, remembered for WRITE
  logic                    rd_valid_reg;
  logic [TAG_W-1:0]        rd_tag_reg;
  logic [DATA_WIDTH-1:0]   rd_data_reg;
  logic                    cpu_ready_reg;
  logic [DATA_WIDTH-1:0]   cpu_rdata_reg;
  logic                    mem_req_reg;
  logic                    mem_we_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg;

  logic [LINES-1:0]        valid_reg;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [LINES];

  logic [IDX-1:0]          req_idx;
  logic [IDX-1:0]          lat_idx;
  logic [TAG_W-1:0]        lat_tag;
  logic                    lookup_hit;
  logic                    fill_done;

  assign req_idx    = bus.cpu_addr[IDX+1:2];
  assign lat_idx    = addr_reg[IDX+1:2];
  assign lat_tag    = addr_reg[ADDR_WIDTH-1:IDX+2];
  assign lookup_hit = rd_valid_reg && (rd_tag_reg == lat_tag);
  assign fill_done  = (state_reg == FILL) && bus.mem_ack;

  assign bus.cpu_ready = cpu_ready_reg;
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.cpu_stall = (state_reg != IDLE) || (bus.cpu_req && !cpu_ready_reg);
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  // Registered read of tag/data when a request is accepted. Writes happen
  // only in FILL/WRITE, so a read never collides with a write.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && bus.cpu_req) begin
      rd_tag_reg  <= tag_mem[req_idx];
      rd_data_reg <= data_mem[req_idx];
    end
  end

  // Line update. A fill writes tag and data. A store writes data only if it
  // hit at LOOKUP. Reset holds the FSM in IDLE, so an aborted access never
  // reaches this block.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[lat_idx]  <= lat_tag;
      data_mem[lat_idx] <= bus.mem_rdata;
    end else if (state_reg == WRITE && bus.mem_ack && hit_reg) begin
      data_mem[lat_idx] <= wdata_reg;
    end
  end

  // Valid bits. These are the only line state that reset has to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (fill_done) begin
      valid_reg[lat_idx] <= 1'b1;
    end
  end

  // Control FSM with registered CPU and backing-memory outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      hit_reg       <= 1'b0;
      rd_valid_reg  <= 1'b0;
      cpu_ready_reg <= 1'b0;
      cpu_rdata_reg <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      cpu_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_reg     <= bus.cpu_addr[ADDR_WIDTH-1:2];
            we_reg       <= bus.cpu_we;
            wdata_reg    <= bus.cpu_wdata;
            rd_valid_reg <= valid_reg[req_idx];
            state_reg    <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_reg <= lookup_hit;
          if (we_reg) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= {addr_reg, 2'b00};
            mem_wdata_reg <= wdata_reg;
            state_reg     <= WRITE;
          end else if (lookup_hit) begin
            cpu_ready_reg <= 1'b1;
            cpu_rdata_reg <= rd_data_reg;
            state_reg     <= IDLE;
          end else begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= {addr_reg, 2'b00};
            state_reg     <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            mem_req_reg   <= 1'b0;
            cpu_ready_reg <= 1'b1;
            cpu_rdata_reg <= bus.mem_rdata;
            state_reg     <= IDLE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            cpu_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  // Saturating load hit/miss counters. Loads are classified at LOOKUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (state_reg == LOOKUP && !we_reg) begin
      if (lookup_hit) begin
        if (hit_cnt_reg != 32'hFFFF_FFFF) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end else begin
        if (miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif
endmodule
